acl_txarq_sched: RTL
====================

ACL_TXARQ_SCHED -- requirements
Module: acl_txarq_sched

Interface
REQ-001 Parameter RETX_W, default 4; width of the retransmit counter and limit.
REQ-002 Parameter NBUF, default 2; number of ping-pong TX ACL buffers (fixed at 2 in this revision).
REQ-003 clk_6M  in  1  sole clock; all state changes on its rising edge.
REQ-004 rstz  in  1  reset, synchronous, active-high: rstz=1 at a clk_6M edge resets all state.
REQ-005 ms_tslot_p  in  1  one-cycle pulse at each master TX slot start.
REQ-006 tx_slot_acl  in  1  current slot carries ACL traffic (not reserved SCO), valid with ms_tslot_p.
REQ-007 rx_hdr_p  in  1  one-cycle pulse when a received header finishes decoding.
REQ-008 dec_hecgood  in  1  HEC of that header passed; valid with rx_hdr_p.
REQ-009 rx_arqn, rx_flow  in  1 each  ARQN and FLOW bits for this link's lt_addr; valid with rx_hdr_p.
REQ-010 buf_load_p  in  1  MCU pulse: one TX buffer filled.
REQ-011 flush_p  in  1  MCU pulse: discard all queued ACL data.
REQ-012 retx_limit  in  RETX_W  maximum transmissions of one packet; 0 = unlimited.
REQ-013 tx_bufsel  out  1  buffer index the link controller reads (drives the TX buffer select).
REQ-014 tx_has_data  out  1  registered; 1 = send payload from tx_bufsel this slot, 0 = send NULL/POLL.
REQ-015 tx_seqn  out  1  SEQN bit for outgoing ACL packets.
REQ-016 buf_occ  out  2  number of filled buffers, 0..2.
REQ-017 retx_cnt  out  RETX_W  retransmissions of current packet.
REQ-018 txdone_p, drop_p, ovf_err_p  out  1 each  packet ACKed / packet dropped at limit / load while full.

Function
REQ-019 FSM states: IDLE, WAIT_ACK; state held in a registered encoding.
REQ-020 IDLE: at ms_tslot_p with tx_slot_acl=1, buf_occ>0 and flow_go=1 -> WAIT_ACK, tx_has_data=1 on the following cycle; otherwise tx_has_data=0.
REQ-021 tx_has_data held stable from the cycle after ms_tslot_p until the next ms_tslot_p.
REQ-022 WAIT_ACK, rx_hdr_p & dec_hecgood & rx_arqn=1: buf_occ-1, tx_bufsel toggles, tx_seqn toggles, retx_cnt=0, txdone_p one cycle, -> IDLE.
REQ-023 WAIT_ACK, rx_hdr_p & dec_hecgood & rx_arqn=0, or next ms_tslot_p with no good header: NAK; retx_cnt+1 (saturating), same buffer retained, -> IDLE.
REQ-024 NAK with retx_limit!=0 and retx_cnt+1 == retx_limit: treated as release (REQ-022 actions) but drop_p instead of txdone_p.
REQ-025 flow_go register: updated to rx_flow on every rx_hdr_p & dec_hecgood in any state; reset 1; while 0, no new payload transmissions start.
REQ-026 rx_hdr_p with dec_hecgood=0: ignored (no ARQN/FLOW update).
REQ-027 buf_load_p with buf_occ<2: buf_occ+1; with buf_occ=2: no change, ovf_err_p one cycle.
REQ-028 buf_load_p coincident with release: buf_occ unchanged, no ovf_err_p.
REQ-029 flush_p: buf_occ=0, retx_cnt=0, -> IDLE, tx_has_data=0 next cycle; tx_seqn and tx_bufsel unchanged; flush_p overrides all same-cycle events except rstz.
REQ-030 ms_tslot_p coincident with ACK in WAIT_ACK: ACK processed first, then REQ-020 evaluated on updated buf_occ in same cycle.

Reset
REQ-031 rstz: state IDLE, tx_bufsel=0, tx_has_data=0, tx_seqn=1, buf_occ=0, retx_cnt=0, flow_go=1, all pulses 0.
REQ-032 rstz mid-packet aborts outstanding WAIT_ACK with no txdone_p/drop_p.

Configuration
REQ-033 Macro ACL_RETX_LIMIT_EN defined: REQ-024 active, drop_p functional.
REQ-034 ACL_RETX_LIMIT_EN undefined: retx_limit ignored, retransmit unbounded, retx_cnt saturates at all-ones, drop_p tied 0.

Structure
REQ-035 Shared package holds FSM state enum, RETX_W default, buf_occ width constant.
REQ-036 One sub-module acl_bufocc_cnt: 0..2 occupancy counter with load/release/flush and overflow pulse.

Verification
REQ-037 Reset, load 1, ACL slot -> tx_has_data=1, tx_bufsel=0, tx_seqn=1; good hdr arqn=1 -> txdone_p, buf_occ=0, tx_bufsel=1, tx_seqn=0.
REQ-038 Load 3 with occ 0 -> buf_occ=2, one ovf_err_p on third load.
REQ-039 retx_limit=3, three NAKs -> retx_cnt 1,2 then drop_p, buf_occ decremented, bufsel toggled (macro on); macro off -> no drop_p, retx_cnt=3.
REQ-040 Good hdr flow=0, buf_occ=2 -> next ACL slots tx_has_data=0; flow=1 hdr -> next slot tx_has_data=1.
REQ-041 Bad-HEC header then ms_tslot_p -> treated as NAK, retx_cnt=1, same tx_bufsel and tx_seqn.
REQ-042 flush_p in WAIT_ACK with buf_occ=2 -> buf_occ=0, IDLE, tx_has_data=0, seqn unchanged.

Source files
------------

// File: rtl/acl_txarq_sched_pkg.sv
// Shared types and constants for the ACL TX ARQ scheduler.
package acl_txarq_sched_pkg;

    localparam int unsigned RETX_W_DEF = 4;
    localparam int unsigned OCC_W      = 2;

    typedef enum logic [0:0] {
        StIdle,
        StWaitAck
    } state_e;

endpackage

// File: rtl/acl_bufocc_cnt.sv
// Ping-pong TX buffer occupancy counter (0..MaxOcc) with load/release/flush and overflow pulse.
module acl_bufocc_cnt
    import acl_txarq_sched_pkg::*;
#(
    parameter int unsigned MaxOcc = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             rel_i,
    input  logic             flush_i,
    output logic [OCC_W-1:0] occ_o,
    output logic [OCC_W-1:0] occ_nxt_o,
    output logic             ovf_o
);

    logic [OCC_W-1:0] occ_d, occ_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        occ_d = occ_q;
        ovf_d = 1'b0;
        if (flush_i) begin
            occ_d = '0;
        end else if (load_i && !rel_i) begin
            if (occ_q == OCC_W'(MaxOcc)) begin
                ovf_d = 1'b1;
            end else begin
                occ_d = occ_q + OCC_W'(1);
            end
        end else if (rel_i && !load_i && (occ_q != '0)) begin
            occ_d = occ_q - OCC_W'(1);
        end
        // load coincident with release leaves the count unchanged
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
        end
    end

    assign occ_o     = occ_q;
    assign occ_nxt_o = occ_d;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/acl_txarq_sched.sv
// ACL TX ARQ scheduler: SEQN/ARQN handling over two ping-pong TX buffers.
// Define ACL_RETX_LIMIT_EN to enable the retransmit limit and drop_p.
module acl_txarq_sched
    import acl_txarq_sched_pkg::*;
#(
    parameter int unsigned RETX_W = RETX_W_DEF,
    parameter int unsigned NBUF   = 2
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              ms_tslot_p,
    input  logic              tx_slot_acl,
    input  logic              rx_hdr_p,
    input  logic              dec_hecgood,
    input  logic              rx_arqn,
    input  logic              rx_flow,
    input  logic              buf_load_p,
    input  logic              flush_p,
    input  logic [RETX_W-1:0] retx_limit,
    output logic              tx_bufsel,
    output logic              tx_has_data,
    output logic              tx_seqn,
    output logic [1:0]        buf_occ,
    output logic [RETX_W-1:0] retx_cnt,
    output logic              txdone_p,
    output logic              drop_p,
    output logic              ovf_err_p
);

    state_e            state_d, state_q;
    logic              bufsel_d, bufsel_q;
    logic              has_d, has_q;
    logic              seqn_d, seqn_q;
    logic [RETX_W-1:0] retx_d, retx_q;
    logic              flow_d, flow_q;
    logic              txdone_d, txdone_q;
    logic              drop_d, drop_q;
    logic              rel;
    logic              good_hdr;
    logic              limit_hit;
    logic [RETX_W:0]   retx_p1;
    logic [RETX_W-1:0] retx_inc;
    logic [OCC_W-1:0]  occ_q, occ_nxt;

    assign good_hdr = rx_hdr_p && dec_hecgood;
    assign retx_p1  = {1'b0, retx_q} + {{RETX_W{1'b0}}, 1'b1};
    assign retx_inc = (&retx_q) ? retx_q : retx_p1[RETX_W-1:0];

`ifdef ACL_RETX_LIMIT_EN
    assign limit_hit = (retx_limit != '0) && (retx_p1 == {1'b0, retx_limit});
`else
    logic unused_retx_limit;
    assign unused_retx_limit = ^retx_limit;
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        bufsel_d = bufsel_q;
        has_d    = has_q;
        seqn_d   = seqn_q;
        retx_d   = retx_q;
        flow_d   = flow_q;
        txdone_d = 1'b0;
        drop_d   = 1'b0;
        rel      = 1'b0;

        if (good_hdr) flow_d = rx_flow;

        if (state_q == StWaitAck) begin
            if (good_hdr && rx_arqn) begin
                rel      = 1'b1;
                txdone_d = 1'b1;
                state_d  = StIdle;
            end else if (good_hdr || ms_tslot_p) begin
                state_d = StIdle;
                if (limit_hit) begin
                    rel    = 1'b1;
                    drop_d = 1'b1;
                end else begin
                    retx_d = retx_inc;
                end
            end
        end

        if (rel) begin
            bufsel_d = ~bufsel_q;
            seqn_d   = ~seqn_q;
            retx_d   = '0;
        end

        // Start decision sees the post-ACK/NAK state and occupancy of this same cycle
        if (ms_tslot_p) begin
            if ((state_d == StIdle) && tx_slot_acl && (occ_nxt != '0) && flow_d) begin
                state_d = StWaitAck;
                has_d   = 1'b1;
            end else begin
                has_d = 1'b0;
            end
        end

        if (flush_p) begin
            state_d  = StIdle;
            bufsel_d = bufsel_q;
            seqn_d   = seqn_q;
            has_d    = 1'b0;
            retx_d   = '0;
            flow_d   = flow_q;
            txdone_d = 1'b0;
            drop_d   = 1'b0;
            rel      = 1'b0;
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rstz) begin
            state_q  <= StIdle;
            bufsel_q <= 1'b0;
            has_q    <= 1'b0;
            seqn_q   <= 1'b1;
            retx_q   <= '0;
            flow_q   <= 1'b1;
            txdone_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bufsel_q <= bufsel_d;
            has_q    <= has_d;
            seqn_q   <= seqn_d;
            retx_q   <= retx_d;
            flow_q   <= flow_d;
            txdone_q <= txdone_d;
            drop_q   <= drop_d;
        end
    end

    acl_bufocc_cnt #(
        .MaxOcc (NBUF)
    ) u_bufocc (
        .clk_i     (clk_6M),
        .rst_i     (rstz),
        .load_i    (buf_load_p),
        .rel_i     (rel),
        .flush_i   (flush_p),
        .occ_o     (occ_q),
        .occ_nxt_o (occ_nxt),
        .ovf_o     (ovf_err_p)
    );

    assign tx_bufsel   = bufsel_q;
    assign tx_has_data = has_q;
    assign tx_seqn     = seqn_q;
    assign buf_occ     = occ_q;
    assign retx_cnt    = retx_q;
    assign txdone_p    = txdone_q;
    assign drop_p      = drop_q;

endmodule
